// File: rtl/strip_preamble.sv
// Receive-side preamble/SFD stripper: validates the 0x55 run and 0xD5 delimiter, then forwards
// payload bytes through a one-byte hold register so the last byte can be flagged with o_eof.
module strip_preamble #(
    parameter int MIN_PREAMBLE = 7,
    parameter int MAX_LEN      = 1518
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_data_valid,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_sof,
    output logic        o_eof,
    output logic [15:0] o_len,
    output logic        o_err
);

    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [2:0]  PCNT_MAX = 3'd7;
    localparam logic [2:0]  MIN_PRE  = 3'(MIN_PREAMBLE);
    localparam logic [15:0] LEN_MAX  = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        S_WAIT,
        S_IDLE,
        S_PRE,
        S_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  pcnt_q, pcnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;

    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;

    // cnt_q is the number of payload bytes received; nonzero in DATA means hold_q is occupied
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        data_d       = 8'h00;
        data_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        len_d        = 16'h0000;
        err_d        = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                if (!i_data_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                cnt_d = 16'h0000;
                if (i_data_valid) begin
                    if (i_data == PRE_BYTE) begin
                        state_d = S_PRE;
                        pcnt_d  = 3'd1;
                    end else begin
                        state_d = S_WAIT;
                        err_d   = 1'b1;
                    end
                end
            end
            S_PRE: begin
                if (i_data_valid) begin
                    if (i_data == PRE_BYTE) begin
                        if (pcnt_q != PCNT_MAX) begin
                            pcnt_d = pcnt_q + 3'd1;
                        end
                    end else if (i_data == SFD_BYTE && pcnt_q >= MIN_PRE) begin
                        state_d = S_DATA;
                        cnt_d   = 16'h0000;
                    end else begin
                        state_d = S_WAIT;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_DATA: begin
                if (i_data_valid) begin
                    if (cnt_q == LEN_MAX) begin
                        // Oversize: close the frame on the held byte and drop the remainder
                        data_d       = hold_q;
                        data_valid_d = 1'b1;
                        sof_d        = (cnt_q == 16'd1);
                        eof_d        = 1'b1;
                        len_d        = cnt_q;
                        err_d        = 1'b1;
                        state_d      = S_WAIT;
                        cnt_d        = 16'h0000;
                    end else begin
                        hold_d = i_data;
                        cnt_d  = cnt_q + 16'd1;
                        if (cnt_q != 16'h0000) begin
                            data_d       = hold_q;
                            data_valid_d = 1'b1;
                            sof_d        = (cnt_q == 16'd1);
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 16'h0000;
                    if (cnt_q != 16'h0000) begin
                        data_d       = hold_q;
                        data_valid_d = 1'b1;
                        sof_d        = (cnt_q == 16'd1);
                        eof_d        = 1'b1;
                        len_d        = cnt_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_WAIT;
            pcnt_q       <= 3'd0;
            cnt_q        <= 16'h0000;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            len_q        <= 16'h0000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            len_q        <= len_d;
            err_q        <= err_d;
        end
    end

    // Hold byte is pure data; its occupancy is tracked by cnt_q, which is reset
    always_ff @(posedge i_clk) begin
        hold_q <= hold_d;
    end

    assign o_data       = data_q;
    assign o_data_valid = data_valid_q;
    assign o_sof        = sof_q;
    assign o_eof        = eof_q;
    assign o_len        = len_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_strip_preamble.sv
// Directed bench for strip_preamble: expected output cycles are queued as stimulus is driven and
// every cycle's outputs are compared against the queued entry, or against all-zero when none is due.
module tb_strip_preamble;

    localparam int MIN_PRE = 7;
    localparam int MAX_LEN = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_data = 8'h00;
    logic        i_data_valid = 1'b0;
    logic [7:0]  o_data;
    logic        o_data_valid;
    logic        o_sof;
    logic        o_eof;
    logic [15:0] o_len;
    logic        o_err;

    strip_preamble #(
        .MIN_PREAMBLE (MIN_PRE),
        .MAX_LEN      (MAX_LEN)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_sof        (o_sof),
        .o_eof        (o_eof),
        .o_len        (o_len),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  d;
        logic        v;
        logic        sof;
        logic        eof;
        logic [15:0] len;
        logic        err;
    } obs_t;

    typedef struct {
        int   c;
        obs_t o;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [7:0]  pay[$];

    // Output monitor: one comparison per cycle, away from the active edge
    always @(negedge i_clk) begin
        obs_t obs;
        obs_t want;
        int   idx;
        if (cyc >= 1) begin
            obs  = {o_data, o_data_valid, o_sof, o_eof, o_len, o_err};
            want = '0;
            idx  = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (idx < 0 && sb[i].c == cyc) idx = i;
            end
            if (idx >= 0) begin
                want = sb[idx].o;
                sb.delete(idx);
            end
            checks++;
            assert (obs === want) passes++;
            else $error("FAIL out_cyc%0d observed d=%h v=%b sof=%b eof=%b len=%0d err=%b expected d=%h v=%b sof=%b eof=%b len=%0d err=%b",
                        cyc, obs.d, obs.v, obs.sof, obs.eof, obs.len, obs.err,
                        want.d, want.v, want.sof, want.eof, want.len, want.err);
        end
    end

    task automatic drv(input logic v, input logic [7:0] d, output int e);
        i_data_valid = v;
        i_data       = d;
        e            = cyc + 1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic exp_out(input int c, input logic [7:0] d, input logic sof, input logic eof,
                           input logic [15:0] len, input logic err);
        exp_t x;
        x.c = c;
        x.o = {d, 1'b1, sof, eof, len, err};
        sb.push_back(x);
    endtask

    task automatic exp_err(input int c);
        exp_t x;
        x.c = c;
        x.o = {8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        sb.push_back(x);
    endtask

    task automatic pre(input int n);
        int e;
        for (int i = 0; i < n; i++) drv(1'b1, 8'h55, e);
    endtask

    // Frame of npre preamble bytes, SFD, payload from pay[] (at most MAX_LEN), one gap cycle
    task automatic good_frame(input int npre);
        int e_prev;
        int e;
        int n;
        n = pay.size();
        pre(npre);
        drv(1'b1, 8'hD5, e);
        e_prev = 0;
        for (int i = 0; i < n; i++) begin
            drv(1'b1, pay[i], e);
            if (i > 0) exp_out(e_prev + 1, pay[i-1], (i == 1), 1'b0, 16'h0000, 1'b0);
            e_prev = e;
        end
        drv(1'b0, 8'h00, e);
        exp_out(e_prev + 1, pay[n-1], (n == 1), 1'b1, 16'(n), 1'b0);
    endtask

    initial begin
        int e;
        int e1;
        int e2;
        int e3;
        int e5;

        i_rst = 1'b1;
        repeat (3) drv(1'b0, 8'h00, e);
        i_rst = 1'b0;
        repeat (2) drv(1'b0, 8'h00, e);

        // Basic three-byte frame with minimum preamble
        pay = '{8'hAA, 8'hBB, 8'hCC};
        good_frame(7);

        // Short preamble: error one cycle after SFD, payload discarded
        pre(5);
        drv(1'b1, 8'hD5, e);
        exp_err(e);
        drv(1'b1, 8'h11, e);
        drv(1'b1, 8'h22, e);
        drv(1'b0, 8'h00, e);
        pay = '{8'h3C};
        good_frame(7);

        // One short of the minimum preamble
        pre(6);
        drv(1'b1, 8'hD5, e);
        exp_err(e);
        drv(1'b0, 8'h00, e);

        // Single-byte frame, then SFD followed directly by a gap
        pay = '{8'h5A};
        good_frame(7);
        pre(7);
        drv(1'b1, 8'hD5, e);
        drv(1'b0, 8'h00, e);
        exp_err(e);
        drv(1'b0, 8'h00, e);

        // Truncated preamble and a foreign byte inside the preamble
        pre(3);
        drv(1'b0, 8'h00, e);
        exp_err(e);
        pre(2);
        drv(1'b1, 8'h12, e);
        exp_err(e);
        drv(1'b0, 8'h00, e);

        // Exactly MAX_LEN payload bytes is not oversize
        pay = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        good_frame(7);

        // Oversize frame truncated at MAX_LEN
        pre(7);
        drv(1'b1, 8'hD5, e);
        drv(1'b1, 8'h01, e1);
        exp_out(e1 + 1, 8'h01, 1'b1, 1'b0, 16'h0000, 1'b0);
        drv(1'b1, 8'h02, e2);
        exp_out(e2 + 1, 8'h02, 1'b0, 1'b0, 16'h0000, 1'b0);
        drv(1'b1, 8'h03, e3);
        exp_out(e3 + 1, 8'h03, 1'b0, 1'b0, 16'h0000, 1'b0);
        drv(1'b1, 8'h04, e);
        drv(1'b1, 8'h05, e5);
        exp_out(e5, 8'h04, 1'b0, 1'b1, 16'd4, 1'b1);
        drv(1'b1, 8'h06, e);
        drv(1'b0, 8'h00, e);
        pay = '{8'h09, 8'h08};
        good_frame(7);

        // Reset mid-frame: first byte already emitted, held byte dropped, rest discarded
        pre(7);
        drv(1'b1, 8'hD5, e);
        drv(1'b1, 8'hE1, e1);
        drv(1'b1, 8'hE2, e2);
        exp_out(e1 + 1, 8'hE1, 1'b1, 1'b0, 16'h0000, 1'b0);
        i_rst = 1'b1;
        drv(1'b1, 8'hE3, e);
        i_rst = 1'b0;
        drv(1'b1, 8'hE4, e);
        drv(1'b1, 8'hE5, e);
        drv(1'b0, 8'h00, e);
        pay = '{8'h42, 8'h43};
        good_frame(7);

        // Bad byte in IDLE, then an over-long preamble that saturates the counter
        drv(1'b1, 8'h12, e);
        exp_err(e);
        drv(1'b0, 8'h00, e);
        pay = '{8'h77};
        good_frame(10);

        repeat (4) drv(1'b0, 8'h00, e);

        checks++;
        assert (sb.size() == 0) passes++;
        else $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
